// File: rtl/stage_3_execute.sv
// Execute stage: combinational ALU plus an iterative 32-cycle multiply/divide unit
// that owns the HI/LO registers.
module stage_3_execute (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  alu_op,
  input  logic        alu_src,
  input  logic [31:0] reg_data_1,
  input  logic [31:0] reg_data_2,
  input  logic [31:0] imm,
  input  logic [4:0]  shamt,
  input  logic        md_start,
  input  logic [1:0]  md_op,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] mem_write_data,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} md_state_e;

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic        bzero_q, bzero_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] op_b;

  assign op_b           = alu_src ? imm : reg_data_2;
  assign mem_write_data = reg_data_2;
  assign zero           = (alu_result == 32'h0);

  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      4'd0:    alu_result = reg_data_1 + op_b;
      4'd1:    alu_result = reg_data_1 - op_b;
      4'd2:    alu_result = reg_data_1 & op_b;
      4'd3:    alu_result = reg_data_1 | op_b;
      4'd4:    alu_result = reg_data_1 ^ op_b;
      4'd5:    alu_result = ~(reg_data_1 | op_b);
      4'd6:    alu_result = {31'h0, $signed(reg_data_1) < $signed(op_b)};
      4'd7:    alu_result = {31'h0, reg_data_1 < op_b};
      4'd8:    alu_result = op_b << shamt;
      4'd9:    alu_result = op_b >> shamt;
      4'd10:   alu_result = $unsigned($signed(op_b) >>> shamt);
      4'd11:   alu_result = {op_b[15:0], 16'h0};
      4'd12:   alu_result = hi_q;
      4'd13:   alu_result = lo_q;
      default: alu_result = 32'h0;
    endcase
  end

  // Datapath for one iteration. acc_q holds {partial, multiplier} for MUL and
  // {remainder, dividend/quotient} for DIV; opb_q is multiplicand or divisor.
  logic [32:0] mul_sum;
  logic [63:0] mul_next, prod_fix;
  logic [32:0] rem_sh;
  logic        div_ge;
  logic [63:0] div_next;
  logic [31:0] quo_fix, rem_fix;
  logic        sgn_a_in, sgn_b_in;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'h0);
    mul_next = {mul_sum, acc_q[31:1]};
    rem_sh   = {acc_q[63:32], acc_q[31]};
    div_ge   = (rem_sh >= {1'b0, opb_q});
    div_next = {div_ge ? (rem_sh[31:0] - opb_q) : rem_sh[31:0], acc_q[30:0], div_ge};
    prod_fix = (sign_a_q ^ sign_b_q) ? -mul_next : mul_next;
    quo_fix  = bzero_q ? 32'hFFFF_FFFF
             : ((sign_a_q ^ sign_b_q) ? -div_next[31:0] : div_next[31:0]);
    rem_fix  = sign_a_q ? -div_next[63:32] : div_next[63:32];
    sgn_a_in = ~md_op[0] & reg_data_1[31];
    sgn_b_in = ~md_op[0] & reg_data_2[31];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (md_start) begin
          acc_d    = {32'h0, sgn_a_in ? -reg_data_1 : reg_data_1};
          opb_d    = sgn_b_in ? -reg_data_2 : reg_data_2;
          sign_a_d = sgn_a_in;
          sign_b_d = sgn_b_in;
          bzero_d  = (reg_data_2 == 32'h0);
          cnt_d    = 5'd0;
          state_d  = md_op[1] ? StDiv : StMul;
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d      = StDone;
          {hi_d, lo_d} = prod_fix;
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
          hi_d    = rem_fix;
          lo_d    = quo_fix;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 64'h0;
      opb_q    <= 32'h0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign md_busy = (state_q != StIdle);
  assign md_done = (state_q == StDone);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_stage_3_execute.sv
// Bench for stage_3_execute: ALU vector table plus scoreboarded multiply/divide runs.
module tb_stage_3_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [31:0] reg_data_1, reg_data_2, imm;
  logic [4:0]  shamt;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] alu_result, mem_write_data, hi, lo;
  logic        zero, md_busy, md_done;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_lo = 32'h0;

  stage_3_execute dut (
    .clock(clock), .reset(reset), .alu_op(alu_op), .alu_src(alu_src),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .imm(imm), .shamt(shamt),
    .md_start(md_start), .md_op(md_op), .alu_result(alu_result), .zero(zero),
    .mem_write_data(mem_write_data), .md_busy(md_busy), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic [31:0] a, b, im;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
  } alu_vec_t;

  alu_vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one multiply/divide op; inject > 0 pulses md_start with junk on that busy cycle.
  task automatic run_md(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int inject);
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [63:0] e;
    alu_op = 4'd13;
    exp_q.push_back({eh, el});
    md_op = op; reg_data_1 = a; reg_data_2 = b; md_start = 1'b1;
    @(posedge clock); #1;
    md_start = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (!md_busy) break;
      busy_cnt++;
      if (md_done) begin
        done_cnt++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({name, " hi"}, hi, e[63:32]);
          check({name, " lo"}, lo, e[31:0]);
        end
      end else if (cyc == 5) begin
        check({name, " stale MFLO"}, alu_result, last_lo);
      end
      if (inject > 0 && cyc == inject) begin
        md_start = 1'b1; md_op = 2'b10; reg_data_1 = 32'hDEAD_BEEF; reg_data_2 = 32'h3;
      end else begin
        md_start = 1'b0;
      end
      @(posedge clock); #1;
    end
    md_start = 1'b0;
    if (done_cnt == 0 && exp_q.size() != 0) e = exp_q.pop_front();
    check({name, " busy cycles"}, busy_cnt, 33);
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " MFLO after"}, alu_result, el);
    last_lo = el;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  1'b0, 32'h7FFFFFFF, 32'h1,        32'h0,        5'd0,  32'h80000000, 1'b0};
    vecs[1]  = '{4'd1,  1'b0, 32'h5,        32'h5,        32'h0,        5'd0,  32'h0,        1'b1};
    vecs[2]  = '{4'd6,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd0,  32'h1,        1'b0};
    vecs[3]  = '{4'd7,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd0,  32'h0,        1'b1};
    vecs[4]  = '{4'd10, 1'b0, 32'h0,        32'h80000000, 32'h0,        5'd4,  32'hF8000000, 1'b0};
    vecs[5]  = '{4'd2,  1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0,        5'd0,  32'h0000F000, 1'b0};
    vecs[6]  = '{4'd3,  1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0,        5'd0,  32'h0000FFF0, 1'b0};
    vecs[7]  = '{4'd4,  1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0,        5'd0,  32'h00000FF0, 1'b0};
    vecs[8]  = '{4'd5,  1'b0, 32'h0,        32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{4'd8,  1'b0, 32'h0,        32'h1,        32'h0,        5'd31, 32'h80000000, 1'b0};
    vecs[10] = '{4'd9,  1'b0, 32'h0,        32'h80000000, 32'h0,        5'd31, 32'h1,        1'b0};
    vecs[11] = '{4'd11, 1'b1, 32'h0,        32'h0,        32'hABCD1234, 5'd0,  32'h12340000, 1'b0};
    vecs[12] = '{4'd0,  1'b1, 32'hA,        32'h55,       32'hFFFFFFFF, 5'd0,  32'h9,        1'b0};
    vecs[13] = '{4'd14, 1'b0, 32'h1,        32'h2,        32'h0,        5'd0,  32'h0,        1'b1};
    vecs[14] = '{4'd6,  1'b0, 32'h1,        32'hFFFFFFFF, 32'h0,        5'd0,  32'h0,        1'b1};

    reset = 1'b0; alu_op = 4'd12; alu_src = 1'b0; reg_data_1 = 32'h0; reg_data_2 = 32'h0;
    imm = 32'h0; shamt = 5'd0; md_start = 1'b0; md_op = 2'b00;
    #12;
    check("reset md_busy", {31'h0, md_busy}, 32'h0);
    check("reset md_done", {31'h0, md_done}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset MFHI", alu_result, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      alu_op = vecs[i].op; alu_src = vecs[i].src; reg_data_1 = vecs[i].a;
      reg_data_2 = vecs[i].b; imm = vecs[i].im; shamt = vecs[i].sh;
      #1;
      check($sformatf("alu vec %0d result", i), alu_result, vecs[i].res);
      check($sformatf("alu vec %0d zero", i), {31'h0, zero}, {31'h0, vecs[i].z});
      check($sformatf("alu vec %0d mem_write_data", i), mem_write_data, vecs[i].b);
    end
    alu_src = 1'b0;
    @(posedge clock); #1;

    run_md("MULT -2x3", 2'b00, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    alu_op = 4'd12; #1;
    check("MFHI after MULT", alu_result, 32'hFFFFFFFF);
    run_md("DIV -7/2", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_md("DIVU 100/0", 2'b11, 32'd100, 32'h0, 32'd100, 32'hFFFFFFFF, 0);
    run_md("DIV min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    run_md("MULTU inject", 2'b01, 32'h00010000, 32'h00030000, 32'h3, 32'h0, 10);
    run_md("DIV -7/0", 2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);

    // Abort a DIVU mid-flight with an asynchronous reset.
    md_op = 2'b11; reg_data_1 = 32'd1000; reg_data_2 = 32'd7; md_start = 1'b1;
    @(posedge clock); #1;
    md_start = 1'b0;
    repeat (15) @(posedge clock);
    #2;
    check("pre-abort md_busy", {31'h0, md_busy}, 32'h1);
    reset = 1'b0; alu_op = 4'd12;
    #1;
    check("abort md_busy", {31'h0, md_busy}, 32'h0);
    check("abort md_done", {31'h0, md_done}, 32'h0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    check("abort MFHI", alu_result, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    last_lo = 32'h0;
    @(posedge clock); #1;
    check("post-reset idle", {31'h0, md_busy}, 32'h0);
    run_md("MULTU max^2", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stage_3_execute.md
STAGE_3_EXECUTE -- requirements
Module: stage_3_execute

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning):
- clock: in, 1, sole clock; all state updates on its rising edge.
- reset: in, 1, asynchronous, active-low.
- alu_op: in, 4, ALU operation select.
- alu_src: in, 1, operand B select: 1 = imm, 0 = reg_data_2.
- reg_data_1: in, 32, operand A.
- reg_data_2: in, 32, register operand B.
- imm: in, 32, sign-extended immediate.
- shamt: in, 5, shift amount.
- md_start: in, 1, begin a multiply/divide operation.
- md_op: in, 2, multiply/divide select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- alu_result: out, 32, result; drives the memory stage address and writeback.
- zero: out, 1, 1 when alu_result == 0.
- mem_write_data: out, 32, reg_data_2 passed through combinationally to the memory stage.
- md_busy: out, 1, multiply/divide unit occupied; the pipeline SHALL stall on it.
- md_done: out, 1, one-cycle completion pulse.
- hi: out, 32, registered HI.
- lo: out, 32, registered LO.

Function
REQ-002 Operand B SHALL equal imm when alu_src = 1, else reg_data_2.
REQ-003 alu_result SHALL be combinational, with alu_op encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR (all 32-bit, wrap, no overflow flag).
- 6 SLT (signed), 7 SLTU (unsigned); result is 32'h1 or 32'h0.
- 8 SLL, 9 SRL, 10 SRA: operand B shifted by shamt.
- 11 LUI: {B[15:0], 16'h0}.
- 12 MFHI: hi. 13 MFLO: lo.
- 14–15: 32'h0.
REQ-004 The multiply/divide FSM SHALL have states IDLE, MUL, DIV, DONE; md_busy = (state != IDLE).
REQ-005 In IDLE, md_start = 1 at an edge SHALL capture reg_data_1/reg_data_2 (absolute values for signed ops, with signs recorded), clear a 5-bit iteration counter, and enter MUL (md_op[1] = 0) or DIV (md_op[1] = 1).
REQ-006 md_start SHALL be ignored in any state other than IDLE.
REQ-007 MUL SHALL perform one shift-add iteration per cycle; DIV SHALL perform one restoring shift-subtract iteration per cycle.
REQ-008 After the 32nd iteration (counter == 31), the FSM SHALL enter DONE and at that same edge write hi/lo with sign-corrected results:
- MULT/MULTU: {hi, lo} = 64-bit product; negate when the operand signs differ (MULT only).
- DIV/DIVU: lo = quotient, hi = remainder.
- DIV quotient sign = signA ^ signB; DIV remainder sign = signA.
REQ-009 DONE SHALL last exactly one cycle with md_done = 1, then return to IDLE.
REQ-010 Latency: start sampled at edge E0; md_busy high from E0 through E33 (33 cycles); hi/lo valid and md_done high in the cycle between E32 and E33.
REQ-011 Division by zero SHALL complete with normal latency and produce hi = operand A as sampled (unsigned or signed value), lo = 32'hFFFFFFFF.
REQ-012 DIV 0x80000000 / 0xFFFFFFFF SHALL produce lo = 0x80000000, hi = 0.
REQ-013 MFHI/MFLO while md_busy = 1 SHALL return the current registered (stale) hi/lo; no forwarding of partial results.
REQ-014 hi and lo SHALL change only on the edge entering DONE.

Reset
REQ-015 reset low SHALL immediately, independent of clock, force:
- state = IDLE, counter = 0;
- hi = 0, lo = 0;
- md_busy = 0, md_done = 0.
REQ-016 Reset asserted mid-operation SHALL abort it with no hi/lo update; after release, the first md_start SHALL begin a fresh operation.
REQ-017 Combinational outputs (alu_result, zero, mem_write_data) SHALL follow inputs during reset; with hi/lo cleared, MFHI returns 0.

Verification
REQ-018 The bench SHALL cover these scenarios:
- ALU: ADD 0x7FFFFFFF + 1 -> alu_result 0x80000000, zero 0.
- ALU: SUB 5 - 5 -> alu_result 0, zero 1.
- ALU: SLT 0xFFFFFFFF vs 1 -> 1; SLTU on the same operands -> 0.
- ALU: SRA 0x80000000 by shamt 4 -> 0xF8000000.
- MULT 0xFFFFFFFE x 3: md_busy high for 33 cycles, md_done pulses once; hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; MFLO then returns 0xFFFFFFFA.
- DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 100 / 0 -> lo = 0xFFFFFFFF, hi = 100.
- DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- md_start pulsed during cycle 10 of a MULTU -> ignored; exactly one md_done, result unaffected.
- reset dropped at iteration 15 of a DIVU -> md_busy 0 and hi = lo = 0 immediately.
- After reset is released, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
